// File: rtl/t06_frame_scheduler.sv
// One full-screen refresh of the snake game's 8080-style LCD. It writes RAM-write,
// then raster-scans the cell grid, querying the CPU and emitting a colour per cell.
module t06_frame_scheduler #(
  parameter int unsigned GRID_W         = 16,
  parameter int unsigned GRID_H         = 16,
  parameter int unsigned BYTES_PER_CELL = 4,
  parameter logic [7:0]  CMD_RAMWR      = 8'h2C
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       frame_req,
  input  logic       game_over,
  input  logic       head,
  input  logic       body,
  input  logic       apple,
  input  logic       wall,
  output logic [3:0] x,
  output logic [3:0] y,
  output logic [7:0] d,
  output logic       wr,
  output logic       dcx,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD_A,
    S_CMD_B,
    S_LOOKUP,
    S_DATA_A,
    S_DATA_B,
    S_DONE
  } state_e;

  localparam logic [3:0] X_LAST = 4'(GRID_W - 1);
  localparam logic [3:0] Y_LAST = 4'(GRID_H - 1);
  localparam logic [8:0] BPC    = 9'(BYTES_PER_CELL);

  state_e     state_q;
  logic [3:0] x_q, y_q;
  logic [7:0] d_q;
  logic       wr_q, dcx_q, busy_q, frame_done_q;
  logic [7:0] colour_q, colour_d;
  logic [7:0] cnt_q;
  logic [8:0] cnt_inc;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    colour_d = 8'h00;
    if (game_over)  colour_d = 8'hE0;
    else if (wall)  colour_d = 8'hFF;
    else if (head)  colour_d = 8'h1C;
    else if (body)  colour_d = 8'h14;
    else if (apple) colour_d = 8'hE0;
  end

  assign cnt_inc = {1'b0, cnt_q} + 9'd1;

  // Each state's bus values are registered as the state exits, so a byte's
  // strobe-low half is visible one cycle after its phase-A state.
  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= S_IDLE;
      x_q          <= 4'd0;
      y_q          <= 4'd0;
      d_q          <= 8'h00;
      wr_q         <= 1'b1;
      dcx_q        <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      colour_q     <= 8'h00;
      cnt_q        <= 8'd0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          wr_q <= 1'b1;
          if (frame_req) begin
            busy_q  <= 1'b1;
            x_q     <= 4'd0;
            y_q     <= 4'd0;
            state_q <= S_CMD_A;
          end
        end
        S_CMD_A: begin
          d_q     <= CMD_RAMWR;
          dcx_q   <= 1'b0;
          wr_q    <= 1'b0;
          state_q <= S_CMD_B;
        end
        S_CMD_B: begin
          wr_q    <= 1'b1;
          state_q <= S_LOOKUP;
        end
        S_LOOKUP: begin
          colour_q <= colour_d;
          cnt_q    <= 8'd0;
          wr_q     <= 1'b1;
          state_q  <= S_DATA_A;
        end
        S_DATA_A: begin
          d_q     <= colour_q;
          dcx_q   <= 1'b1;
          wr_q    <= 1'b0;
          state_q <= S_DATA_B;
        end
        S_DATA_B: begin
          wr_q  <= 1'b1;
          cnt_q <= cnt_inc[7:0];
          if (cnt_inc < BPC) begin
            state_q <= S_DATA_A;
          end else if (x_q == X_LAST && y_q == Y_LAST) begin
            x_q          <= 4'd0;
            y_q          <= 4'd0;
            frame_done_q <= 1'b1;
            state_q      <= S_DONE;
          end else if (x_q == X_LAST) begin
            x_q     <= 4'd0;
            y_q     <= y_q + 4'd1;
            state_q <= S_LOOKUP;
          end else begin
            x_q     <= x_q + 4'd1;
            state_q <= S_LOOKUP;
          end
        end
        S_DONE: begin
          x_q     <= 4'd0;
          y_q     <= 4'd0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign d          = d_q;
  assign wr         = wr_q;
  assign dcx        = dcx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
